// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package instr_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Little-endian lane select: idx 0 is the least significant byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/loader_word_serializer.sv
// Latches one 32-bit word on i_load and emits its four bytes LSB-first, one per cycle.
module loader_word_serializer
  import instr_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  output logic        o_active,
  output logic [7:0]  o_byte,
  output logic [1:0]  o_idx,
  output logic        o_last_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_active;
  logic [7:0]  r_byte;

  // Byte register holds its value once the word is finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word   <= '0;
      r_idx    <= '0;
      r_active <= 1'b0;
      r_byte   <= '0;
    end else if (i_load) begin
      r_word   <= i_word;
      r_idx    <= 2'd0;
      r_active <= 1'b1;
      r_byte   <= byte_lane(i_word, 2'd0);
    end else if (r_active) begin
      if (r_idx == 2'd3) begin
        r_active <= 1'b0;
      end else begin
        r_idx  <= r_idx + 2'd1;
        r_byte <= byte_lane(r_word, r_idx + 2'd1);
      end
    end
  end

  assign o_active    = r_active;
  assign o_byte      = r_byte;
  assign o_idx       = r_idx;
  assign o_last_byte = r_active && (r_idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: accepts instruction words on a valid/ready stream and writes them
// little-endian into byte-addressed instruction memory, one byte per cycle.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  loader_state_t     r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr_ptr, w_addr_ptr_d;
  logic              r_last;
  logic              r_word_ready, w_word_ready_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_error, w_error_d;
  logic [15:0]       r_words, w_words_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;

  logic              w_start_ok, w_misaligned, w_accept, w_overflow, w_load, w_word_end;
  logic              w_ser_active, w_ser_last_byte;
  logic [7:0]        w_ser_byte;
  logic [1:0]        w_ser_idx;

  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == ERR));
  assign w_misaligned = |base_addr[1:0];
  assign w_accept     = (r_state == ACCEPT) && word_valid && r_word_ready;
  // One extra bit so a word ending exactly at MEM_BYTES is still legal.
  assign w_overflow   = ({1'b0, r_addr_ptr} + (ADDR_W+1)'(BYTES_PER_WORD))
                        > (ADDR_W+1)'(MEM_BYTES);
  assign w_load       = w_accept && !w_overflow;
  assign w_word_end   = (r_state == WRITE) && w_ser_last_byte;

  loader_word_serializer u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_word      (word_data),
    .o_active    (w_ser_active),
    .o_byte      (w_ser_byte),
    .o_idx       (w_ser_idx),
    .o_last_byte (w_ser_last_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, ERR: if (start) w_state_next = w_misaligned ? ERR : ACCEPT;
      ACCEPT:    if (w_accept) w_state_next = w_overflow ? ERR : WRITE;
      WRITE:     if (w_ser_last_byte) w_state_next = r_last ? DONE : ACCEPT;
      DONE:      w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_word_ready_d = (w_state_next == ACCEPT);
    w_busy_d       = (w_state_next != IDLE);
    w_done_d       = (w_state_next == DONE);

    w_error_d = r_error;
    if (w_start_ok)                 w_error_d = w_misaligned;
    else if (w_accept && w_overflow) w_error_d = 1'b1;

    w_words_d = r_words;
    if (w_start_ok)                         w_words_d = '0;
    else if (w_word_end && r_words != 16'hFFFF) w_words_d = r_words + 16'd1;

    w_addr_ptr_d = r_addr_ptr;
    if (w_start_ok)      w_addr_ptr_d = base_addr;
    else if (w_word_end) w_addr_ptr_d = r_addr_ptr + ADDR_W'(BYTES_PER_WORD);

    w_mem_addr_d = r_mem_addr;
    if (w_load) begin
      w_mem_addr_d = r_addr_ptr;
    end else if ((r_state == WRITE) && w_ser_active && !w_ser_last_byte) begin
      w_mem_addr_d = r_addr_ptr + ADDR_W'(w_ser_idx) + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_ptr   <= '0;
      r_last       <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words      <= '0;
      r_mem_addr   <= '0;
    end else begin
      r_addr_ptr   <= w_addr_ptr_d;
      r_last       <= w_load ? word_last : r_last;
      r_word_ready <= w_word_ready_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
      r_words      <= w_words_d;
      r_mem_addr   <= w_mem_addr_d;
    end
  end

  assign word_ready   = r_word_ready;
  assign mem_we       = w_ser_active;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = w_ser_byte;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a 16-byte memory and a byte-write model.
module tb_instr_mem_loader;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [31:0]   word_data = '0;
  logic          word_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy, done, error;
  logic [15:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_snap;
  logic [7:0] tb_mem [0:15];

  instr_mem_loader #(.MEM_BYTES(16), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .word_last    (word_last),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[3:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    while (!word_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, word_ready}, 32'd1);
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    tick();
    word_valid = 1'b0;
  endtask

  task automatic expect_bytes(input logic [31:0] base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      check("we", {31'd0, mem_we}, 32'd1);
      check("addr", mem_addr, base + i);
      check("wdata", {24'd0, mem_wdata}, {24'd0, w[8*i +: 8]});
      check("ready_low", {31'd0, word_ready}, 32'd0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    #3 rst_n = 1'b0;
    tick(); tick(); tick();
    check("rst_ready", {31'd0, word_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word at 0
    start = 1'b1; base_addr = 32'h0;
    tick();
    start = 1'b0;
    check("t1_ready", {31'd0, word_ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_word(32'h00500093, 1'b1);
    expect_bytes(32'h0, 32'h00500093);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_we_off", {31'd0, mem_we}, 32'd0);
    check("t1_words", {16'd0, words_loaded}, 32'd1);
    tick();
    check("t1_done_off", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Two-word stream with valid gaps
    start = 1'b1; base_addr = 32'h0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("t2_hold_ready", {31'd0, word_ready}, 32'd1);
    check("t2_hold_we", {31'd0, mem_we}, 32'd0);
    send_word(32'h00500093, 1'b0);
    expect_bytes(32'h0, 32'h00500093);
    check("t2_back_ready", {31'd0, word_ready}, 32'd1);
    check("t2_no_done", {31'd0, done}, 32'd0);
    tick(); tick(); tick();
    send_word(32'h00A00113, 1'b1);
    expect_bytes(32'h4, 32'h00A00113);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_words", {16'd0, words_loaded}, 32'd2);
    check("t2_readback", {tb_mem[7], tb_mem[6], tb_mem[5], tb_mem[4]}, 32'h00A00113);
    tick();

    // Bounds: words at 0x8 and 0xC fit, the third overflows
    start = 1'b1; base_addr = 32'h8;
    tick();
    start = 1'b0;
    send_word(32'hA1B2C3D4, 1'b0);
    expect_bytes(32'h8, 32'hA1B2C3D4);
    send_word(32'h01020304, 1'b0);
    expect_bytes(32'hC, 32'h01020304);
    wr_snap = wr_count;
    send_word(32'hCAFEF00D, 1'b0);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_ready", {31'd0, word_ready}, 32'd0);
    check("t3_we", {31'd0, mem_we}, 32'd0);
    check("t3_words", {16'd0, words_loaded}, 32'd2);
    tick(); tick(); tick();
    check("t3_no_writes", wr_count, wr_snap);
    check("t3_addr_hold", mem_addr, 32'hF);
    check("t3_error_sticky", {31'd0, error}, 32'd1);

    // Misaligned start from ERR, then a good start clears error
    start = 1'b1; base_addr = 32'h2;
    tick();
    start = 1'b0;
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_words_clr", {16'd0, words_loaded}, 32'd0);
    check("t4_ready", {31'd0, word_ready}, 32'd0);
    wr_snap = wr_count;
    tick(); tick();
    check("t4_no_writes", wr_count, wr_snap);
    start = 1'b1; base_addr = 32'h0;
    tick();
    start = 1'b0;
    check("t4_error_clr", {31'd0, error}, 32'd0);
    check("t4_ready_ok", {31'd0, word_ready}, 32'd1);
    send_word(32'h12345678, 1'b1);
    expect_bytes(32'h0, 32'h12345678);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_words", {16'd0, words_loaded}, 32'd1);
    check("t4_readback", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h12345678);
    tick();

    // Start pulse during WRITE is ignored
    start = 1'b1; base_addr = 32'h4;
    tick();
    start = 1'b0;
    send_word(32'h0BADF00D, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t6_we", {31'd0, mem_we}, 32'd1);
      check("t6_addr", mem_addr, 32'h4 + i);
      if (i == 1) begin
        start = 1'b1; base_addr = 32'h100;
      end
      tick();
      start = 1'b0;
    end
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_addr_end", mem_addr, 32'h7);
    check("t6_readback", {tb_mem[7], tb_mem[6], tb_mem[5], tb_mem[4]}, 32'h0BADF00D);
    tick(); tick();
    check("t6_no_restart", {31'd0, busy}, 32'd0);
    check("t6_ready_off", {31'd0, word_ready}, 32'd0);

    // Asynchronous reset during byte 2
    start = 1'b1; base_addr = 32'h0;
    tick();
    start = 1'b0;
    send_word(32'hDEADBEEF, 1'b1);
    check("t5_b0", {24'd0, mem_wdata}, 32'hEF);
    tick();
    check("t5_b1", {24'd0, mem_wdata}, 32'hBE);
    tick();
    check("t5_idx2_we", {31'd0, mem_we}, 32'd1);
    check("t5_idx2_addr", mem_addr, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_we", {31'd0, mem_we}, 32'd0);
    check("t5_addr", mem_addr, 32'd0);
    check("t5_wdata", {24'd0, mem_wdata}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_ready", {31'd0, word_ready}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_error", {31'd0, error}, 32'd0);
    check("t5_words", {16'd0, words_loaded}, 32'd0);
    tick();
    check("t5_mem", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h1234BEEF);
    rst_n = 1'b1;
    tick();
    check("t5_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Program loader that writes the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes them as four little-endian bytes, one per cycle, to consecutive addresses. Fetch reads back instruction = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}. The loader is the write-side counterpart of the fetch read path and runs before the core is released from reset.

Parameters:
MEM_BYTES, 1024, instruction memory depth in bytes; must be a multiple of 4.
ADDR_W, 32, width of the byte address and of base_addr; matches program_counter width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse that begins a load at base_addr; honoured only in IDLE.
base_addr  in  ADDR_W  first byte address; sampled on an accepted start; bits [1:0] must be 0.
word_valid  in  1  word_data and word_last are valid.
word_ready  out  1  loader accepts a word this cycle.
word_data  in  32  instruction word.
word_last  in  1  marks the final word of the program.
mem_we  out  1  byte write strobe.
mem_addr  out  ADDR_W  byte address for the write.
mem_wdata  out  8  byte to write.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last byte of the last word is written.
error  out  1  sticky error flag; cleared by the next accepted start or by reset.
words_loaded  out  16  count of words fully written since the last start; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_loaded=0. Asserting rst_n low mid-word aborts the word. Bytes already written stay in memory. mem_we falls without waiting for a clock edge.
- States: IDLE, ACCEPT, WRITE (byte index 0..3), DONE, ERR.
- IDLE: start=1 latches addr_ptr=base_addr, clears error and words_loaded, then goes to ACCEPT next cycle. If base_addr[1:0]!=0, it sets error and goes to ERR instead.
- ACCEPT: word_ready=1 (registered, asserted in this state only). On word_valid&&word_ready:
  - If addr_ptr+4 > MEM_BYTES, the word is dropped, error=1, and the FSM goes to ERR.
  - Otherwise it latches word_data and word_last and goes to WRITE with idx=0.
  - word_valid=0 holds the FSM in ACCEPT with no timeout.
- WRITE: mem_we=1, mem_addr=addr_ptr+idx, mem_wdata=word[8*idx+7 : 8*idx], so byte 0 is the LSB. idx increments every cycle.
  - After idx=3: addr_ptr+=4 and words_loaded+=1 (saturating). The FSM goes to DONE if last was set, otherwise to ACCEPT.
  - Throughput is 1 word per 5 cycles (1 accept + 4 writes). word_ready=0 throughout WRITE.
- DONE: done=1 for exactly one cycle, then IDLE. mem_we=0.
- ERR: busy=1, error=1, no writes. A start pulse behaves as it does in IDLE. Reset also exits ERR.
- start while in ACCEPT, WRITE or DONE is ignored, with no effect on state or outputs.
- Address arithmetic is ADDR_W-bit unsigned. The overflow check uses ADDR_W+1-bit compare, so the final word at MEM_BYTES-4 is legal.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- All outputs are registered.

Decomposition:
- Package instr_mem_pkg: loader_state_t enum {IDLE, ACCEPT, WRITE, DONE, ERR}; localparam BYTES_PER_WORD=4; function byte_lane(word, idx) returning an 8-bit slice.
- One natural sub-module, loader_word_serializer: it takes a latched 32-bit word plus a start strobe and emits 4 bytes with idx and a last_byte flag. The top level keeps the FSM, address pointer, bounds check and counters.

Test Plan:
- Reset check: hold rst_n=0, then release; drive start at base 0x0 with word 0x00500093, last=1 -> writes 93@0, 00@1, 50@2, 00@3 on consecutive cycles; done pulses one cycle later; words_loaded=1.
- Stream: words 0x00500093, 0x00A00113 (last on the second), with word_valid gaps of 3 cycles -> bytes 0x93,0x00,0x50,0x00,0x13,0x01,0xA0,0x00 at addrs 0..7. Readback at PC=4 gives 0x00A00113. words_loaded=2.
- Bound: MEM_BYTES=16, base 0x8, 3 words -> words at 0x8 and 0xC are written; the third word is dropped; error=1; state ERR; no mem_we for the third word.
- Misaligned start: base 0x2 -> error=1 next cycle, zero writes. A following start at 0x0 clears error and loads normally.
- Async reset mid-word: assert rst_n low while idx=2 of word 0xDEADBEEF -> mem_we=0 immediately; only EF@0 and BE@1 were written; all outputs are at reset values.
- Ignored start: pulse start during WRITE with base 0x100 -> the load continues at the original addresses; no restart.
